sequence_gen_tx: RTL and testbench

//  Serial pattern transmitter; the send side of the serial sequence-detector link.

---
 rtl/sequence_gen_tx_if.sv | 23 ++
 rtl/sequence_gen_tx.sv | 103 ++++++++++
 tb/tb_sequence_gen_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sequence_gen_tx_if.sv
// Load handshake and serial output bundle between a frame source and sequence_gen_tx.
interface sequence_gen_tx_if #(
  parameter int FRAME_W = 5
);
  logic [FRAME_W-1:0] load_data;
  logic               load_valid;
  logic               load_ready;
  logic               data;
  logic               data_en;
  logic               sop;
  logic               eop;
  logic               busy;

  modport master (
    output load_data, load_valid,
    input  load_ready, data, data_en, sop, eop, busy
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, data, data_en, sop, eop, busy
  );
endinterface

// File: rtl/sequence_gen_tx.sv
// Serial frame transmitter: parallel frame in over valid/ready, MSB-first bit stream out
// with sop/eop markers and an optional fixed idle gap between frames.
//
// state | meaning
// IDLE  | waiting for a frame, load_ready=1
// SHIFT | one frame bit per cycle on data, data_en=1
// GAP   | forced idle cycles after eop, data_en=0
module sequence_gen_tx #(
  parameter int   FRAME_W    = 5,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sequence_gen_tx_if.slave tx
);

  localparam int BW = $clog2(FRAME_W);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [BW-1:0]      bit_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               accept;

  // Ready is a pure decode of registered state, so it only moves on clock edges.
  assign tx.load_ready = (state == S_IDLE)
                      || (state == S_SHIFT && GAP_CYCLES == 0 && bit_cnt == BIT_LAST)
                      || (state == S_GAP && gap_cnt == GAP_LAST);
  assign accept = tx.load_valid && tx.load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx.data    <= IDLE_LEVEL;
      tx.data_en <= 1'b0;
      tx.sop     <= 1'b0;
      tx.eop     <= 1'b0;
      tx.busy    <= 1'b0;
    end else if (accept) begin
      // Ready is only ever high at a terminal point, so every accept starts a fresh frame.
      state      <= S_SHIFT;
      shreg      <= tx.load_data;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx.data    <= tx.load_data[FRAME_W-1];
      tx.data_en <= 1'b1;
      tx.sop     <= 1'b1;
      tx.eop     <= 1'b0;
      tx.busy    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: ;
        S_SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            tx.data <= shreg[FRAME_W-2];
            tx.sop  <= 1'b0;
            tx.eop  <= (bit_cnt + 1'b1 == BIT_LAST);
          end else begin
            state      <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            gap_cnt    <= '0;
            tx.data    <= IDLE_LEVEL;
            tx.data_en <= 1'b0;
            tx.sop     <= 1'b0;
            tx.eop     <= 1'b0;
            tx.busy    <= (GAP_CYCLES > 0);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= S_IDLE;
            tx.busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          tx.data    <= IDLE_LEVEL;
          tx.data_en <= 1'b0;
          tx.sop     <= 1'b0;
          tx.eop     <= 1'b0;
          tx.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_gen_tx.sv
// Directed bench for sequence_gen_tx: one instance without gap, one with a 2-cycle gap.
module tb_sequence_gen_tx;

  logic clk;
  logic rst;

  sequence_gen_tx_if #(.FRAME_W(5)) i0 ();
  sequence_gen_tx_if #(.FRAME_W(5)) i2 ();

  sequence_gen_tx #(.FRAME_W(5), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx(i0.slave)
  );
  sequence_gen_tx #(.FRAME_W(5), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tx(i2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {data, data_en, sop, eop, busy, load_ready}
  logic [5:0] o0, o2;
  assign o0 = {i0.data, i0.data_en, i0.sop, i0.eop, i0.busy, i0.load_ready};
  assign o2 = {i2.data, i2.data_en, i2.sop, i2.eop, i2.busy, i2.load_ready};

  localparam logic [5:0] IDLE_O = 6'b000001;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference detector for pattern 10111 plus protocol watchers
  int         hits = 0;
  int         viol = 0;
  logic [4:0] win  = '0;
  bit         mon_on = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (i0.data_en && !i0.busy) viol++;
      if (i2.data_en && !i2.busy) viol++;
      if (i0.sop && i0.eop) viol++;
      if (i2.sop && i2.eop) viol++;
      if (mon_on && i0.data_en) begin
        win = {win[3:0], i0.data};
        if (win == 5'b10111) hits++;
      end
    end
  end

  function automatic logic [5:0] shift_o(input logic b, input int k, input logic rdy);
    return {b, 1'b1, (k == 0), (k == 4), 1'b1, rdy};
  endfunction

  // Single frame on the no-gap instance with load_valid dropped right after accept
  task automatic send_frame(input string tag, input logic [4:0] frame, input logic [4:0] exp_bits);
    @(negedge clk);
    i0.load_data  = frame;
    i0.load_valid = 1'b1;
    @(posedge clk); #1;
    i0.load_valid = 1'b0;
    i0.load_data  = ~frame;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("%s_bit%0d", tag, k), 32'(o0), 32'(shift_o(exp_bits[4-k], k, k == 4)));
    end
    @(posedge clk); #1;
    chk($sformatf("%s_idle", tag), 32'(o0), 32'(IDLE_O));
  endtask

  typedef struct {
    logic [4:0] frame;
    logic [4:0] exp_bits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] seq;
    logic [4:0] fa, fb;
    logic [5:0] e;

    vecs[0] = '{5'b10111, 5'b10111};
    vecs[1] = '{5'b10011, 5'b10011};
    vecs[2] = '{5'b01010, 5'b01010};
    vecs[3] = '{5'b11111, 5'b11111};
    vecs[4] = '{5'b00001, 5'b00001};

    i0.load_valid = 1'b0; i0.load_data = '0;
    i2.load_valid = 1'b0; i2.load_data = '0;
    rst = 1'b1;
    #12;
    chk("reset_dut0", 32'(o0), 32'(IDLE_O));
    chk("reset_dut2", 32'(o2), 32'(IDLE_O));
    @(negedge clk);
    rst = 1'b0;

    // T1 and variations: table of single frames
    foreach (vecs[i]) send_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].exp_bits);

    // T2: held valid, back-to-back frames with no bubble
    seq = 10'b10111_11111;
    @(negedge clk);
    i0.load_data  = 5'b10111;
    i0.load_valid = 1'b1;
    @(posedge clk); #1;
    i0.load_data = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e = {seq[9-k], 1'b1, (k == 0 || k == 5), (k == 4 || k == 9), 1'b1, (k == 4 || k == 9)};
      chk($sformatf("b2b_%0d", k), 32'(o0), 32'(e));
      if (k == 5) i0.load_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_idle", 32'(o0), 32'(IDLE_O));

    // T4: request waits while busy; only the value at the accept edge is sent
    seq = 10'b11111_01010;
    @(negedge clk);
    i0.load_data  = 5'b11111;
    i0.load_valid = 1'b1;
    @(posedge clk); #1;
    i0.load_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < 10)
        e = {seq[9-k], 1'b1, (k == 0 || k == 5), (k == 4 || k == 9), 1'b1, (k == 4 || k == 9)};
      else
        e = IDLE_O;
      chk($sformatf("hold_%0d", k), 32'(o0), 32'(e));
      if (k == 1) begin i0.load_data = 5'b00110; i0.load_valid = 1'b1; end
      if (k == 2) i0.load_data = 5'b01010;
      if (k == 5) i0.load_valid = 1'b0;
      if (k == 6) i0.load_data = 5'b11000;
    end

    // T3: two-cycle gap between frames, ready only in the last gap cycle
    fa = 5'b10111;
    fb = 5'b11001;
    @(negedge clk);
    i2.load_data  = fa;
    i2.load_valid = 1'b1;
    @(posedge clk); #1;
    i2.load_data = fb;
    for (int t = 0; t < 15; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      if (t < 5)       e = {fa[4-t], 1'b1, (t == 0), (t == 4), 1'b1, 1'b0};
      else if (t < 7)  e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (t == 6)};
      else if (t < 12) e = {fb[11-t], 1'b1, (t == 7), (t == 11), 1'b1, 1'b0};
      else if (t < 14) e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (t == 13)};
      else             e = IDLE_O;
      chk($sformatf("gap_%0d", t), 32'(o2), 32'(e));
      if (t == 7) i2.load_valid = 1'b0;
    end

    // T5: asynchronous reset in the middle of a frame
    @(negedge clk);
    i0.load_data  = 5'b10111;
    i0.load_valid = 1'b1;
    @(posedge clk); #1;
    i0.load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("pre_rst_%0d", k), 32'(o0), 32'(shift_o(fa[4-k], k, 1'b0)));
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'(o0), 32'(IDLE_O));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_frame("after_rst", 5'b10011, 5'b10011);

    // T6: detector link sees exactly two patterns
    win    = '0;
    hits   = 0;
    mon_on = 1;
    send_frame("det_a", 5'b10111, 5'b10111);
    send_frame("det_b", 5'b00000, 5'b00000);
    send_frame("det_c", 5'b10111, 5'b10111);
    @(negedge clk);
    mon_on = 0;
    chk("detector_hits", 32'(hits), 32'd2);
    chk("protocol_viol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
